// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and helpers for the 16-way round-robin arbiter.
package arb_pkg;

  localparam int N        = 16;
  localparam int W        = 4;
  localparam int MAX_HOLD = 8;

  localparam logic [W-1:0] PTR_RST = 4'd15;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/cod_prio_mask_16_4.sv
// Combinational 16->4 priority encoder whose highest-priority position is ptr, descending and
// wrapping. Implemented as rotate so that req[ptr] lands on bit 15, MSB-first encode, un-rotate.
module cod_prio_mask_16_4
  import arb_pkg::*;
(
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [N-1:0] rot;
  logic [W-1:0] rot_idx;

  // rot[j] = req[j + ptr + 1], so rot[15] = req[ptr] and rot[0] = req[ptr + 1]
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      localparam logic [W-1:0] OFS = W'(gi + 1);
      logic [W-1:0] src;
      assign src     = OFS + ptr;
      assign rot[gi] = req[src];
    end
  endgenerate

  always_comb begin
    rot_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (rot[i]) rot_idx = W'(i);
    end
  end

  assign any = |rot;
  assign idx = rot_idx + ptr + W'(1);

endmodule

// File: rtl/arbitro_rr_16.sv
// Round-robin arbiter for 16 requesters with registered one-hot grant and encoded index.
// Optional owner preemption after MAX_HOLD cycles is built when ARB_TIMEOUT_EN is defined.
module arbitro_rr_16
  import arb_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] entrada,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         valid
);

  state_t       state_reg, state_next;
  logic [W-1:0] ptr_reg, ptr_next;
  logic [N-1:0] grant_reg, grant_next;
  logic [W-1:0] idx_reg, idx_next;
  logic         valid_reg, valid_next;

  logic [N-1:0] arb_req;
  logic [W-1:0] win_idx;
  logic         win_any;
  logic         timeout;
  logic         owner_keep;
  logic         new_grant;

  // The current owner never competes; once released its bit is already zero anyway.
  assign arb_req = (state_reg == GRANT) ? (entrada & ~grant_reg) : entrada;

  cod_prio_mask_16_4 u_prio (
    .req (arb_req),
    .ptr (ptr_reg),
    .idx (win_idx),
    .any (win_any)
  );

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_reg, hold_cnt_next;

  // Asserted during the owner's MAX_HOLD-th consecutive grant cycle.
  assign timeout = ({1'b0, hold_cnt_reg} + 9'd1) >= 9'(MAX_HOLD);

  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (new_grant)
      hold_cnt_next = '0;
    else if (state_reg == GRANT && hold_cnt_reg != 8'hFF)
      hold_cnt_next = hold_cnt_reg + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_cnt_reg <= '0;
    else     hold_cnt_reg <= hold_cnt_next;
  end
`else
  assign timeout = 1'b0;
`endif

  assign owner_keep = entrada[idx_reg] && !(timeout && win_any);

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    new_grant  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (win_any) new_grant = 1'b1;
      end
      GRANT: begin
        if (!owner_keep) begin
          if (win_any) begin
            new_grant = 1'b1;
          end else begin
            state_next = IDLE;
            grant_next = '0;
            idx_next   = '0;
            valid_next = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        idx_next   = '0;
        valid_next = 1'b0;
      end
    endcase

    // The new winner drops to lowest priority for the next arbitration.
    if (new_grant) begin
      state_next = GRANT;
      grant_next = onehot(win_idx);
      idx_next   = win_idx;
      valid_next = 1'b1;
      ptr_next   = win_idx - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= PTR_RST;
      grant_reg <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
    end
  end

  assign grant     = grant_reg;
  assign grant_idx = idx_reg;
  assign valid     = valid_reg;

endmodule
